mem_tag_responder: RTL

- Memory-side responder for the tagged split-transaction memory interface used by the fetch/icache subsystem and the data side.
- Accepts one request per cycle and grants a nonzero transaction tag, or tag 0 to reject.
- After a fixed latency, returns the requested 64-bit block with its tag.
- Holds the backing block store, so it is both the synthesizable memory model and the reference responder for bench work.

---
 rtl/mem_tag_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_tag_responder.sv
// mem_tag_responder: tagged split-transaction memory responder that owns the backing block store.
// Latency: a load accepted in cycle N is selected for return in cycle N+LATENCY; data/tag registers update at the end of that cycle.
// Backpressure: none on the return path; requests get tag 0 while every tag is busy and must be retried.
//
// Ports:
//   clock, reset             - system clock, synchronous active-high reset
//   req_valid/req_store      - request strobe and load(0)/store(1) select
//   req_addr/req_data        - byte address (block = addr[3 +: log2(DEPTH)]) and store data
//   mem2proc_transaction_tag - combinational grant, 0 = rejected or no request
//   mem2proc_data/_data_tag  - registered return data and its tag, tag 0 = no data

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module mem_tag_responder #(
    parameter int NUM_TAGS = `NUM_MEM_TAGS,
    parameter int LATENCY  = 4,     // must be >= 1
    parameter int DEPTH    = 256,
    parameter int TAG_W    = $clog2(NUM_TAGS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_store,
    input  logic [31:0]      req_addr,
    input  logic [63:0]      req_data,
    output logic [TAG_W-1:0] mem2proc_transaction_tag,
    output logic [63:0]      mem2proc_data,
    output logic [TAG_W-1:0] mem2proc_data_tag
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam int IDX_W = $clog2(DEPTH);

    // Per-tag state; tag 0 is reserved so arrays are indexed 1..NUM_TAGS.
    logic [NUM_TAGS:1] busy_q;
    logic [CNT_W-1:0]  cnt_q [1:NUM_TAGS];
    logic [63:0]       buf_q [1:NUM_TAGS];

    // Backing store: intentionally not reset, contents survive reset.
    logic [63:0]       store_q [DEPTH];

    logic [TAG_W-1:0]  data_tag_q;
    logic [63:0]       data_q;

    logic [TAG_W-1:0]  grant_tag;
    logic [TAG_W-1:0]  ret_tag_d;
    logic [63:0]       ret_data_d;
    logic              accept;
    logic              load_acc;
    logic              store_acc;
    logic [IDX_W-1:0]  blk;

    // Upper address bits and the byte offset alias onto the block index.
    assign blk = req_addr[3 +: IDX_W];

    // Lowest-numbered free tag; busy_q reflects the start of the cycle, so a
    // tag being returned this cycle is still seen as busy.
    always_comb begin
        grant_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!busy_q[t]) begin
                grant_tag = TAG_W'(t);
            end
        end
    end

    assign mem2proc_transaction_tag = (req_valid && !reset) ? grant_tag : '0;
    assign accept    = (mem2proc_transaction_tag != '0);
    assign load_acc  = accept && !req_store;
    assign store_acc = accept && req_store;

    // Lowest-numbered ready tag (busy with an expired countdown) returns next.
    always_comb begin
        ret_tag_d  = '0;
        ret_data_d = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (busy_q[t] && (cnt_q[t] == '0)) begin
                ret_tag_d  = TAG_W'(t);
                ret_data_d = buf_q[t];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            data_tag_q <= '0;
            data_q     <= '0;
            for (int t = 1; t <= NUM_TAGS; t++) begin
                cnt_q[t] <= '0;
                buf_q[t] <= '0;
            end
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (ret_tag_d == TAG_W'(t)) begin
                    busy_q[t] <= 1'b0;
                end else if (busy_q[t] && (cnt_q[t] != '0)) begin
                    cnt_q[t] <= cnt_q[t] - 1'b1;
                end
                // Granted tags are always free, so this never collides with a return.
                // Stores take a tag but never occupy it.
                if (load_acc && (grant_tag == TAG_W'(t))) begin
                    busy_q[t] <= 1'b1;
                    cnt_q[t]  <= CNT_W'(LATENCY - 1);
                    buf_q[t]  <= store_q[blk];   // snapshot: later stores are not seen
                end
            end
            data_tag_q <= ret_tag_d;
            data_q     <= ret_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (store_acc) begin
            store_q[blk] <= req_data;
        end
    end

    assign mem2proc_data_tag = data_tag_q;
    assign mem2proc_data     = data_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:3+IDX_W], req_addr[2:0]};

endmodule
